// File: rtl/cordic_atanh_pkg.sv
// Shared types and constants for the hyperbolic-vectoring atanh CORDIC engine.
// Word format is signed Q(WI.WF). Angles and operands use the same word.
package cordic_atanh_pkg;

    localparam int WI = 8;
    localparam int WF = 16;
    localparam int W  = WI + WF;
    localparam int N  = 13;
    localparam int M  = 2;
    localparam int WC = 4;
    localparam int AW = 4;

    typedef logic signed [W-1:0] word_t;
    typedef logic [WC-1:0]       cnt_t;
    typedef logic [AW-1:0]       addr_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_NEG,
        S_MAIN,
        S_DONE
    } state_t;

    localparam word_t ONE     = word_t'(1 << WF);
    localparam word_t NEG_ONE = -ONE;
    localparam word_t SAT_POS = {1'b0, {(W-1){1'b1}}};
    localparam word_t SAT_NEG = {1'b1, {(W-2){1'b0}}, 1'b1};

    localparam cnt_t K_FIRST = cnt_t'(M);
    localparam cnt_t I_LAST  = cnt_t'(N);
    localparam cnt_t REP_A   = cnt_t'(4);
    localparam cnt_t REP_B   = cnt_t'(13);

    // Hyperbolic CORDIC only converges if these main indices run twice.
    function automatic logic is_repeat(input cnt_t i);
        return (i == REP_A) || (i == REP_B);
    endfunction

endpackage

// File: rtl/cordic_atanh_rom.sv
// Angle table: three negative-iteration entries atanh(1-2^-(k+2)) for k=2..0,
// followed by atanh(2^-i) for i=1..13, all rounded to the nearest Q8.16 LSB.
module cordic_ROM
    import cordic_atanh_pkg::*;
(
    input  addr_t iAddr,
    output word_t oAngle
);

    always_comb begin
        case (iAddr)
            4'd0:  oAngle = 24'h01B78D;
            4'd1:  oAngle = 24'h015AA1;
            4'd2:  oAngle = 24'h00F914;
            4'd3:  oAngle = 24'h008C9F;
            4'd4:  oAngle = 24'h004163;
            4'd5:  oAngle = 24'h00202B;
            4'd6:  oAngle = 24'h001005;
            4'd7:  oAngle = 24'h000801;
            4'd8:  oAngle = 24'h000400;
            4'd9:  oAngle = 24'h000200;
            4'd10: oAngle = 24'h000100;
            4'd11: oAngle = 24'h000080;
            4'd12: oAngle = 24'h000040;
            4'd13: oAngle = 24'h000020;
            4'd14: oAngle = 24'h000010;
            4'd15: oAngle = 24'h000008;
        endcase
    end

endmodule

// File: rtl/cordic_atanh.sv
// Iterative hyperbolic-vectoring CORDIC: starts from x=1, y=t, z=0 and drives y
// to zero, leaving atanh(t) in z. One iteration per clock, start/busy/done handshake.
module cordic_atanh
    import cordic_atanh_pkg::*;
(
    input  logic         iClk,
    input  logic         iRst,
    input  logic         iStart,
    input  logic [W-1:0] iT,
    output logic         oBusy,
    output logic         oDone,
    output logic         oErr,
    output logic [W-1:0] oZ
);

    state_t state_q, state_d;
    word_t  x_q, x_d, y_q, y_d, z_q, z_d, z_out_q, z_out_d;
    cnt_t   cnt_q, cnt_d;
    addr_t  addr_q, addr_d;
    logic   stall_q, stall_d;
    logic   busy_q, busy_d, done_q, done_d, err_q, err_d;

    logic   in_neg, neg_dir;
    cnt_t   sh_amt;
    word_t  sh_x, sh_y, op_x, op_y, angle;
    word_t  x_step, y_step, z_step;

    cordic_ROM u_rom (
        .iAddr (addr_q),
        .oAngle(angle)
    );

    assign in_neg  = (state_q == S_NEG);
    assign neg_dir = y_q[W-1];
    assign sh_amt  = in_neg ? cnt_q + cnt_t'(2) : cnt_q;
    assign sh_x    = x_q >>> sh_amt;
    assign sh_y    = y_q >>> sh_amt;

    // Negative iterations rotate by (1 - 2^-s) instead of 2^-s.
    assign op_x = in_neg ? y_q - sh_y : sh_y;
    assign op_y = in_neg ? x_q - sh_x : sh_x;

    assign x_step = neg_dir ? x_q + op_x  : x_q - op_x;
    assign y_step = neg_dir ? y_q + op_y  : y_q - op_y;
    assign z_step = neg_dir ? z_q - angle : z_q + angle;

    // NOTE: every _d starts from its _q so no path through this block can infer a latch.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        z_d     = z_q;
        z_out_d = z_out_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        stall_d = stall_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (iStart) begin
                    state_d = S_CHECK;
                    x_d     = ONE;
                    y_d     = $signed(iT);
                    z_d     = '0;
                    cnt_d   = K_FIRST;
                    addr_d  = '0;
                    stall_d = 1'b0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                end
            end
            S_CHECK: begin
                if ((y_q >= ONE) || (y_q <= NEG_ONE)) begin
                    state_d = S_DONE;
                    z_out_d = neg_dir ? SAT_NEG : SAT_POS;
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d = S_NEG;
                end
            end
            S_NEG: begin
                x_d    = x_step;
                y_d    = y_step;
                z_d    = z_step;
                addr_d = addr_q + addr_t'(1);
                if (cnt_q == '0) begin
                    state_d = S_MAIN;
                    cnt_d   = cnt_t'(1);
                end else begin
                    cnt_d = cnt_q - cnt_t'(1);
                end
            end
            S_MAIN: begin
                x_d = x_step;
                y_d = y_step;
                z_d = z_step;
                if (is_repeat(cnt_q) && !stall_q) begin
                    stall_d = 1'b1;
                end else begin
                    stall_d = 1'b0;
                    if (cnt_q == I_LAST) begin
                        state_d = S_DONE;
                        z_out_d = z_step;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        cnt_d  = cnt_q + cnt_t'(1);
                        addr_d = addr_q + addr_t'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iClk or posedge iRst) begin
        if (iRst) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            z_q     <= '0;
            z_out_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            stall_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            z_q     <= z_d;
            z_out_q <= z_out_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            stall_q <= stall_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign oBusy = busy_q;
    assign oDone = done_q;
    assign oErr  = err_q;
    assign oZ    = z_out_q;

endmodule

// File: tb/tb_cordic_atanh.sv
// Directed plus randomized bench for cordic_atanh: a step-level model of the
// hyperbolic vectoring recurrence gives exact oZ; real atanh guards the model.
module tb_cordic_atanh;

    logic        iClk = 1'b0;
    logic        iRst;
    logic        iStart;
    logic [23:0] iT;
    logic        oBusy, oDone, oErr;
    logic [23:0] oZ;

    int total = 0;
    int bad   = 0;

    cordic_atanh dut (
        .iClk  (iClk),
        .iRst  (iRst),
        .iStart(iStart),
        .iT    (iT),
        .oBusy (oBusy),
        .oDone (oDone),
        .oErr  (oErr),
        .oZ    (oZ)
    );

    always #5 iClk = ~iClk;

    task automatic check(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, got, got, exp, exp);
        end
    endtask

    function automatic real pow2n(input int s);
        real p = 1.0;
        for (int j = 0; j < s; j++) p = p / 2.0;
        return p;
    endfunction

    function automatic real atanh_r(input real v);
        return 0.5 * $ln((1.0 + v) / (1.0 - v));
    endfunction

    function automatic int to_lsb(input real a);
        return $rtoi(a * 65536.0 + 0.5);
    endfunction

    // Vectoring recurrence: 3 negative steps (s = 4,3,2), then i = 1..13 with 4 and 13 doubled.
    function automatic int model_z(input int t);
        int x, y, z, a, mx, my, xs, ys;
        if (t >= 65536)  return 8388607;
        if (t <= -65536) return -8388607;
        x = 65536;
        y = t;
        z = 0;
        for (int k = 2; k >= 0; k--) begin
            a  = to_lsb(atanh_r(1.0 - pow2n(k + 2)));
            mx = x - (x >>> (k + 2));
            my = y - (y >>> (k + 2));
            if (y < 0) begin x = x + my; y = y + mx; z = z - a; end
            else       begin x = x - my; y = y - mx; z = z + a; end
        end
        for (int i = 1; i <= 13; i++) begin
            for (int r = 0; r < ((i == 4 || i == 13) ? 2 : 1); r++) begin
                a  = to_lsb(atanh_r(pow2n(i)));
                xs = x >>> i;
                ys = y >>> i;
                if (y < 0) begin x = x + ys; y = y + xs; z = z - a; end
                else       begin x = x - ys; y = y - xs; z = z + a; end
            end
        end
        return z;
    endfunction

    // Ends on the falling edge right after the accepting rising edge.
    task automatic start(input int t);
        @(negedge iClk);
        iT     = t[23:0];
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
    endtask

    // Counts rising edges until oDone, bounded so a stuck DUT still reaches the summary.
    task automatic wait_done(output int lat);
        lat = 0;
        while (!oDone && lat < 40) begin
            @(negedge iClk);
            lat++;
        end
    endtask

    task automatic run(input string tag, input int t, input bit near_check);
        int  lat, got;
        real ref_z, diff;
        start(t);
        check({tag, "_busy"}, int'(oBusy), 1);
        check({tag, "_notdone"}, int'(oDone), 0);
        wait_done(lat);
        got = int'($signed(oZ));
        if (t >= 65536 || t <= -65536) begin
            // Out-of-range argument is resolved by CHECK on the edge after accept.
            check({tag, "_lat"}, int'(lat <= 2), 1);
            check({tag, "_err"}, int'(oErr), 1);
        end else begin
            check({tag, "_lat"}, lat, 19);
            check({tag, "_err"}, int'(oErr), 0);
        end
        check({tag, "_z"}, got, model_z(t));
        check({tag, "_busy_done"}, int'(oBusy), 0);
        if (near_check) begin
            ref_z = atanh_r(real'(t) / 65536.0) * 65536.0;
            diff  = real'(got) - ref_z;
            if (diff < 0.0) diff = -diff;
            total++;
            assert (diff <= 256.0) else begin
                bad++;
                $error("FAIL %s_real: got %0d expected %0f (within 256 LSB)", tag, got, ref_z);
            end
        end
    endtask

    initial begin
        int lat, t, mag;
        iRst   = 1'b1;
        iStart = 1'b0;
        iT     = '0;
        repeat (3) @(negedge iClk);
        check("rst_busy", int'(oBusy), 0);
        check("rst_done", int'(oDone), 0);
        check("rst_err",  int'(oErr),  0);
        check("rst_z",    int'(oZ),    0);
        iRst = 1'b0;
        @(negedge iClk);
        check("idle_done", int'(oDone), 0);

        run("zero",      0,        1'b1);
        run("half",      32768,    1'b1);
        run("neg_half", -32768,    1'b1);
        run("p99",       64881,    1'b0);
        run("one",       65536,    1'b0);
        check("one_sat", int'(oZ), 24'h7FFFFF);
        run("neg_one",  -65536,    1'b0);
        check("neg_one_sat", int'(oZ), 24'h800001);
        run("min",      -8388608,  1'b0);

        // DONE holds its result until the next accepted start.
        repeat (4) @(negedge iClk);
        check("hold_done", int'(oDone), 1);
        check("hold_err",  int'(oErr),  1);
        check("hold_z",    int'(oZ),    24'h800001);

        // A start pulse mid-run is ignored and iT is not resampled.
        start(20000);
        repeat (5) @(negedge iClk);
        iT     = 24'hFFEC78;
        iStart = 1'b1;
        @(negedge iClk);
        iStart = 1'b0;
        wait_done(lat);
        check("ign_lat", lat, 13);
        check("ign_z",   int'($signed(oZ)), model_z(20000));
        check("ign_err", int'(oErr), 0);

        // Asynchronous reset mid-run clears everything at once.
        start(40000);
        repeat (7) @(negedge iClk);
        iRst = 1'b1;
        #1;
        check("mid_rst_busy", int'(oBusy), 0);
        check("mid_rst_done", int'(oDone), 0);
        check("mid_rst_err",  int'(oErr),  0);
        check("mid_rst_z",    int'(oZ),    0);
        @(negedge iClk);
        iRst = 1'b0;
        run("after_rst", 40000, 1'b1);

        for (int n = 0; n < 20; n++) begin
            mag = int'($urandom_range(58982, 0));
            t   = ($urandom_range(1, 0) == 1) ? -mag : mag;
            run("rnd", t, 1'b1);
        end
        for (int n = 0; n < 6; n++) begin
            mag = int'($urandom_range(65471, 58983));
            t   = ($urandom_range(1, 0) == 1) ? -mag : mag;
            run("rnd_hi", t, 1'b0);
        end
        for (int n = 0; n < 3; n++) begin
            mag = int'($urandom_range(8388607, 65536));
            t   = ($urandom_range(1, 0) == 1) ? -mag : mag;
            run("rnd_err", t, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
